// File: rtl/temp_sensor_pkg.sv
// Shared constants, frame layout and FSM encoding for the temperature sensor reader.
package temp_sensor_pkg;

    localparam int unsigned FRAME_BITS = 12;
    localparam int unsigned RAW_MSB    = 11;
    localparam int unsigned RAW_LSB    = 2;
    localparam int unsigned FAULT_BIT  = 0;
    localparam int unsigned RAW_W      = 10;
    localparam int unsigned SUM_W      = 12;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        DONE
    } state_e;

    // Sign-extend a raw quarter-degree sample to accumulator width.
    function automatic logic signed [SUM_W-1:0] sext_raw(input logic signed [RAW_W-1:0] r);
        return {{(SUM_W-RAW_W){r[RAW_W-1]}}, r};
    endfunction

endpackage

// File: rtl/temp_avg4.sv
// 4-sample moving average of raw quarter-degree readings, output in whole degrees C.
module temp_avg4
    import temp_sensor_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic signed [RAW_W-1:0] sample,
    output logic signed [7:0]       avg
);

    logic signed [RAW_W-1:0] win_q [4];
    logic signed [RAW_W-1:0] win_d [4];
    logic                    primed_q;
    logic signed [SUM_W-1:0] sum_c;

    // avg already reflects a sample being pushed this cycle, so the caller can register it directly.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            win_d[i] = win_q[i];
        end
        if (push) begin
            win_d[0] = sample;
            for (int i = 1; i < 4; i++) begin
                win_d[i] = primed_q ? win_q[i-1] : sample;
            end
        end
        sum_c = sext_raw(win_d[0]) + sext_raw(win_d[1]) + sext_raw(win_d[2]) + sext_raw(win_d[3]);
        // Dropping the low 4 bits of a signed sum is an arithmetic shift right by 4.
        avg   = sum_c[SUM_W-1:4];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                win_q[i] <= '0;
            end
            primed_q <= 1'b0;
        end else if (push) begin
            for (int i = 0; i < 4; i++) begin
                win_q[i] <= win_d[i];
            end
            primed_q <= 1'b1;
        end
    end

endmodule

// File: rtl/temp_sensor_reader.sv
// Periodic SPI-style reader for a 12-bit serial temperature sensor with fault rejection
// and a smoothed, registered whole-degree output.
module temp_sensor_reader
    import temp_sensor_pkg::*;
#(
    parameter int unsigned       CLK_DIV       = 4,
    parameter int unsigned       SAMPLE_PERIOD = 1000,
    parameter logic signed [7:0] RESET_TEMP    = 8'sd25
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              miso,
    output logic              sclk,
    output logic              cs_n,
    output logic signed [7:0] temperature,
    output logic              temp_valid,
    output logic              sensor_fault
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned PER_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int unsigned BIT_W = $clog2(FRAME_BITS);

    state_e                  state_q;
    logic [DIV_W-1:0]        div_q;
    logic [BIT_W-1:0]        bit_q;
    logic [PER_W-1:0]        per_q;
    logic [PER_W-1:0]        per_d;
    logic [FRAME_BITS-1:0]   shift_q;
    logic                    cs_n_q;
    logic                    sclk_q;
    logic signed [7:0]       temp_q;
    logic                    valid_q;
    logic                    fault_q;
    logic                    div_last_c;
    logic                    push_c;
    logic signed [7:0]       avg_c;

    assign div_last_c = (div_q == DIV_W'(CLK_DIV - 1));
    assign push_c     = (state_q == DONE) && !shift_q[FAULT_BIT];
    assign per_d      = (per_q == PER_W'(SAMPLE_PERIOD - 1)) ? '0 : per_q + PER_W'(1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            per_q <= '0;
        end else begin
            per_q <= per_d;
        end
    end

    // Conversion sequencer; cs_n/sclk are registered alongside the state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (per_q == '0) begin
                        state_q <= SETUP;
                        cs_n_q  <= 1'b0;
                        div_q   <= '0;
                    end
                end
                SETUP: begin
                    if (div_last_c) begin
                        state_q <= SHIFT;
                        bit_q   <= BIT_W'(FRAME_BITS - 1);
                        div_q   <= '0;
                    end else begin
                        div_q <= div_q + DIV_W'(1);
                    end
                end
                SHIFT: begin
                    if (!div_last_c) begin
                        div_q <= div_q + DIV_W'(1);
                    end else begin
                        div_q <= '0;
                        if (!sclk_q) begin
                            sclk_q  <= 1'b1;
                            shift_q <= {shift_q[FRAME_BITS-2:0], miso};
                        end else begin
                            sclk_q <= 1'b0;
                            if (bit_q == '0) begin
                                state_q <= DONE;
                                cs_n_q  <= 1'b1;
                            end else begin
                                bit_q <= bit_q - BIT_W'(1);
                            end
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    cs_n_q  <= 1'b1;
                    sclk_q  <= 1'b0;
                end
            endcase
        end
    end

    temp_avg4 u_avg (
        .clk    (clk),
        .reset  (reset),
        .push   (push_c),
        .sample ($signed(shift_q[RAW_MSB:RAW_LSB])),
        .avg    (avg_c)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            temp_q  <= RESET_TEMP;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            valid_q <= push_c;
            if (state_q == DONE) begin
                fault_q <= shift_q[FAULT_BIT];
            end
            if (push_c) begin
                temp_q <= avg_c;
            end
        end
    end

    assign cs_n         = cs_n_q;
    assign sclk         = sclk_q;
    assign temperature  = temp_q;
    assign temp_valid   = valid_q;
    assign sensor_fault = fault_q;

endmodule

// File: tb/tb_temp_sensor_reader.sv
// Directed bench for temp_sensor_reader: behavioural sensor model plus hand-computed expectations.
module tb_temp_sensor_reader;

    localparam int unsigned CLK_DIV       = 4;
    localparam int unsigned SAMPLE_PERIOD = 200;
    localparam int          CS_LOW_CYC    = 4 + 96;

    logic              clk;
    logic              reset;
    logic              miso;
    logic              sclk;
    logic              cs_n;
    logic signed [7:0] temperature;
    logic              temp_valid;
    logic              sensor_fault;

    int          n_checks    = 0;
    int          n_errors    = 0;
    int          cyc         = 0;
    int          bit_idx     = 11;
    logic        prev_sclk   = 1'b0;
    logic        prev_cs     = 1'b1;
    logic [11:0] frame_word  = '0;
    int          cs_low      = 0;
    int          sclk_rise   = 0;
    int          vcnt        = 0;
    int          frame_start = 0;
    int          rel_cyc     = 0;

    temp_sensor_reader #(
        .CLK_DIV       (CLK_DIV),
        .SAMPLE_PERIOD (SAMPLE_PERIOD),
        .RESET_TEMP    (8'sd25)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .miso         (miso),
        .sclk         (sclk),
        .cs_n         (cs_n),
        .temperature  (temperature),
        .temp_valid   (temp_valid),
        .sensor_fault (sensor_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] mk(input int raw, input bit rsvd, input bit flt);
        logic [9:0] r;
        r = 10'(raw);
        return {r, rsvd, flt};
    endfunction

    // One clock: sample at the falling edge, act as the sensor, update monitors.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (cs_n) begin
            bit_idx = 11;
            miso    = frame_word[11];
        end else if (prev_sclk && !sclk) begin
            bit_idx--;
        end
        if (!cs_n) begin
            // Garbage while sclk is high: only the capture instant may matter.
            miso = sclk ? 1'($urandom) : frame_word[bit_idx];
        end
        if (!cs_n) cs_low++;
        if (!prev_sclk && sclk) sclk_rise++;
        if (prev_cs && !cs_n) frame_start = cyc;
        if (temp_valid) vcnt++;
        prev_sclk = sclk;
        prev_cs   = cs_n;
    endtask

    task automatic run_frame(input string tag, input logic [11:0] fw, input int exp_before,
                             input int exp_temp, input int exp_valid, input int exp_fault);
        int n;
        int low0;
        int rise0;
        int v0;
        frame_word = fw;
        low0  = cs_low;
        rise0 = sclk_rise;
        v0    = vcnt;
        n     = 0;
        while (cs_n && n < 2 * int'(SAMPLE_PERIOD)) begin
            tick();
            n++;
        end
        if (cs_n) begin
            check({tag, "_start_timeout"}, 1, 0);
            return;
        end
        n = 0;
        while (!cs_n && n < 40 * int'(CLK_DIV)) begin
            tick();
            n++;
        end
        if (!cs_n) begin
            check({tag, "_end_timeout"}, 1, 0);
            return;
        end
        check({tag, "_done_temp"}, int'(temperature), exp_before);
        check({tag, "_done_valid"}, int'(temp_valid), 0);
        tick();
        check({tag, "_temp"}, int'(temperature), exp_temp);
        check({tag, "_valid"}, int'(temp_valid), exp_valid);
        check({tag, "_fault"}, int'(sensor_fault), exp_fault);
        tick();
        check({tag, "_pulses"}, vcnt - v0, exp_valid);
        check({tag, "_cs_low"}, cs_low - low0, CS_LOW_CYC);
        check({tag, "_sclk_rises"}, sclk_rise - rise0, 12);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) tick();
        check("rst_temp", int'(temperature), 25);
        check("rst_cs_n", int'(cs_n), 1);
        reset   = 1'b1;
        rel_cyc = cyc;
    endtask

    initial begin
        int prev;
        int exp2 [4];
        int bef2 [4];
        int n;
        exp2 = '{36, 37, 38, 40};
        bef2 = '{35, 36, 37, 38};
        reset = 1'b0;
        miso  = 1'b0;
        repeat (3) tick();
        check("rst_temp", int'(temperature), 25);
        check("rst_valid", int'(temp_valid), 0);
        check("rst_fault", int'(sensor_fault), 0);
        check("rst_cs_n", int'(cs_n), 1);
        check("rst_sclk", int'(sclk), 0);

        // Scenario 1: first frame right after release, 35.25 C.
        frame_word = mk(141, 0, 0);
        reset      = 1'b1;
        rel_cyc    = cyc;
        run_frame("s1", mk(141, 0, 0), 25, 35, 1, 0);
        check("s1_first_start", frame_start, rel_cyc + 1);

        // Scenario 2: 40.0 C frames ramp the average; reserved bit set and ignored.
        for (int i = 0; i < 4; i++) begin
            prev = frame_start;
            run_frame($sformatf("s2_%0d", i), mk(160, 1, 0), bef2[i], exp2[i], 1, 0);
            check($sformatf("s2_%0d_period", i), frame_start - prev, int'(SAMPLE_PERIOD));
        end

        // Scenario 4: a fault frame leaves the output alone.
        do_reset();
        run_frame("s4_prime", mk(141, 0, 0), 25, 35, 1, 0);
        run_frame("s4_fault", mk(400, 0, 1), 35, 35, 0, 1);
        run_frame("s4_good", mk(141, 0, 0), 35, 35, 1, 0);

        // Scenario 3: signed extremes, each from a freshly primed filter.
        do_reset();
        run_frame("s3_m1", mk(-1, 0, 0), 25, -1, 1, 0);
        do_reset();
        run_frame("s3_min", mk(-512, 0, 0), 25, -128, 1, 0);
        do_reset();
        run_frame("s3_max", mk(511, 0, 0), 25, 127, 1, 0);

        // Scenario 6: reset in the middle of bit 5.
        frame_word = mk(300, 0, 0);
        n = 0;
        while (cs_n && n < 2 * int'(SAMPLE_PERIOD)) begin
            tick();
            n++;
        end
        n = 0;
        while (!(!cs_n && bit_idx == 5 && !sclk) && n < 40 * int'(CLK_DIV)) begin
            tick();
            n++;
        end
        check("s6_reached_bit5", int'(!cs_n && bit_idx == 5), 1);
        reset = 1'b0;
        tick();
        check("s6_cs_n", int'(cs_n), 1);
        check("s6_sclk", int'(sclk), 0);
        check("s6_temp", int'(temperature), 25);
        tick();
        reset   = 1'b1;
        rel_cyc = cyc;
        run_frame("s6_fresh", mk(100, 0, 0), 25, 25, 1, 0);
        check("s6_first_start", frame_start, rel_cyc + 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
